// File: rtl/decode_pkg.sv
// Shared types for the RV32I decode stage: opcode map, ALU operations,
// immediate formats and the ID/EX pipeline bundle.
package decode_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10,
    ALU_ADD_PC = 4'd11
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4,
    IMM_R = 3'd5
  } imm_fmt_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    alu_op_e     alu_op;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic [2:0]  funct3;
    logic        illegal;
  } idex_t;

endpackage

// File: rtl/reg_file.sv
// Integer register file: two asynchronous reads with write-through bypass,
// one synchronous write; x0 always reads zero.
module reg_file #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data
);

  logic [XLEN-1:0] regs [NREGS];
  logic            wr_ok;

  assign wr_ok = wb_en && (wb_rd != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // Bypass lets an instruction in decode see the value being written back this cycle.
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (wr_ok && (wb_rd == rs1))  rs1_data = wb_data;
    else if (rs1 != '0)           rs1_data = regs[rs1];
    if (wr_ok && (wb_rd == rs2))  rs2_data = wb_data;
    else if (rs2 != '0)           rs2_data = regs[rs2];
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: field/immediate/control decode, register read,
// load-use hazard detection and the ID/EX pipeline register.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  input  logic [31:0]     instr_in,
  input  logic            valid_in,
  input  logic            stall_in,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            stall_fe,
  output logic            valid_out,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] imm,
  output logic [3:0]      alu_op,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            branch,
  output logic            jump,
  output logic [2:0]      funct3_out,
  output logic            illegal
);

  function automatic logic [31:0] imm_gen(input logic [31:0] ins, input imm_fmt_e fmt);
    logic [31:0] r;
    case (fmt)
      IMM_I:   r = {{20{ins[31]}}, ins[31:20]};
      IMM_S:   r = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   r = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U:   r = {ins[31:12], 12'b0};
      IMM_J:   r = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: r = '0;
    endcase
    return r;
  endfunction

  // instr[30] selects SUB only for register-register ops; SRAI/SRA use it for both.
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt, input logic is_op);
    alu_op_e r;
    case (f3)
      3'd0:    r = (is_op && alt) ? ALU_SUB : ALU_ADD;
      3'd1:    r = ALU_SLL;
      3'd2:    r = ALU_SLT;
      3'd3:    r = ALU_SLTU;
      3'd4:    r = ALU_XOR;
      3'd5:    r = alt ? ALU_SRA : ALU_SRL;
      3'd6:    r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

  logic [6:0]      opcode;
  logic [4:0]      rs1_f, rs2_f, rd_f;
  logic [2:0]      f3;
  imm_fmt_e        fmt;
  alu_op_e         alu_d;
  logic            rw_d, mr_d, mw_d, br_d, jp_d, ill_d;
  logic            use_rs1, use_rs2;
  logic [XLEN-1:0] rs1_rd, rs2_rd;
  logic            hz;
  idex_t           idex_d, idex_p1;
  logic            vld_p1;

  assign opcode = instr_in[6:0];
  assign rd_f   = instr_in[11:7];
  assign f3     = instr_in[14:12];
  assign rs1_f  = instr_in[19:15];
  assign rs2_f  = instr_in[24:20];

  always_comb begin
    fmt     = IMM_R;
    alu_d   = ALU_ADD;
    rw_d    = 1'b0;
    mr_d    = 1'b0;
    mw_d    = 1'b0;
    br_d    = 1'b0;
    jp_d    = 1'b0;
    ill_d   = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opcode)
      OPC_LUI:    begin fmt = IMM_U; alu_d = ALU_PASS_B; rw_d = 1'b1; end
      OPC_AUIPC:  begin fmt = IMM_U; alu_d = ALU_ADD_PC; rw_d = 1'b1; end
      OPC_JAL:    begin fmt = IMM_J; rw_d = 1'b1; jp_d = 1'b1; end
      OPC_JALR:   begin fmt = IMM_I; rw_d = 1'b1; jp_d = 1'b1; use_rs1 = 1'b1; end
      OPC_BRANCH: begin fmt = IMM_B; alu_d = ALU_SUB; br_d = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OPC_LOAD:   begin fmt = IMM_I; rw_d = 1'b1; mr_d = 1'b1; use_rs1 = 1'b1; end
      OPC_STORE:  begin fmt = IMM_S; mw_d = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OPC_OP_IMM: begin
        fmt     = IMM_I;
        alu_d   = alu_from_f3(f3, instr_in[30], 1'b0);
        rw_d    = 1'b1;
        use_rs1 = 1'b1;
      end
      OPC_OP:     begin
        fmt     = IMM_R;
        alu_d   = alu_from_f3(f3, instr_in[30], 1'b1);
        rw_d    = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      default:    ill_d = 1'b1;
    endcase
    if (rd_f == 5'd0) rw_d = 1'b0;
  end

  reg_file #(.XLEN(XLEN), .NREGS(NREGS)) u_reg_file (
    .clk      (clk),
    .rst      (rst),
    .rs1      (rs1_f),
    .rs2      (rs2_f),
    .rs1_data (rs1_rd),
    .rs2_data (rs2_rd),
    .wb_en    (wb_en),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data)
  );

  // Control bits are gated by valid_in so an invalid entry can never commit side effects.
  always_comb begin
    idex_d           = '0;
    idex_d.pc        = pc_in;
    idex_d.rs1_data  = rs1_rd;
    idex_d.rs2_data  = rs2_rd;
    idex_d.rs1       = rs1_f;
    idex_d.rs2       = rs2_f;
    idex_d.rd        = rd_f;
    idex_d.imm       = imm_gen(instr_in, fmt);
    idex_d.alu_op    = alu_d;
    idex_d.reg_write = rw_d && valid_in;
    idex_d.mem_read  = mr_d && valid_in;
    idex_d.mem_write = mw_d && valid_in;
    idex_d.branch    = br_d && valid_in;
    idex_d.jump      = jp_d && valid_in;
    idex_d.funct3    = f3;
    idex_d.illegal   = ill_d && valid_in;
  end

  assign hz = vld_p1 && idex_p1.mem_read && (idex_p1.rd != 5'd0) && valid_in &&
              ((use_rs1 && (rs1_f == idex_p1.rd)) || (use_rs2 && (rs2_f == idex_p1.rd)));

  assign stall_fe = hz && !flush && !stall_in && !rst;

  // ID/EX boundary (_p1)
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      idex_p1 <= '0;
      vld_p1  <= 1'b0;
    end else if (!stall_in) begin
      if (hz) begin
        idex_p1 <= '0;
        vld_p1  <= 1'b0;
      end else begin
        idex_p1 <= idex_d;
        vld_p1  <= valid_in;
      end
    end
  end

  assign valid_out  = vld_p1;
  assign pc_out     = idex_p1.pc;
  assign rs1_data   = idex_p1.rs1_data;
  assign rs2_data   = idex_p1.rs2_data;
  assign rs1        = idex_p1.rs1;
  assign rs2        = idex_p1.rs2;
  assign rd         = idex_p1.rd;
  assign imm        = idex_p1.imm;
  assign alu_op     = idex_p1.alu_op;
  assign reg_write  = idex_p1.reg_write;
  assign mem_read   = idex_p1.mem_read;
  assign mem_write  = idex_p1.mem_write;
  assign branch     = idex_p1.branch;
  assign jump       = idex_p1.jump;
  assign funct3_out = idex_p1.funct3;
  assign illegal    = idex_p1.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with hand-computed expectations.
module tb_decode_stage;
  import decode_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] pc_in;
  logic [31:0] instr_in;
  logic        valid_in;
  logic        stall_in;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        stall_fe;
  logic        valid_out;
  logic [31:0] pc_out;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] imm;
  logic [3:0]  alu_op;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        branch;
  logic        jump;
  logic [2:0]  funct3_out;
  logic        illegal;

  int checks;
  int errors;

  localparam logic [31:0] I_ADDI = 32'h00500093;  // addi x1,x0,5
  localparam logic [31:0] I_ADD  = 32'h001101B3;  // add  x3,x2,x1
  localparam logic [31:0] I_ADD0 = 32'h001001B3;  // add  x3,x0,x1
  localparam logic [31:0] I_LW   = 32'h0000A103;  // lw   x2,0(x1)
  localparam logic [31:0] I_BEQ  = 32'hFE000CE3;  // beq  x0,x0,-8
  localparam logic [31:0] I_JAL  = 32'h008000EF;  // jal  x1,8
  localparam logic [31:0] I_LUI  = 32'h123452B7;  // lui  x5,0x12345

  decode_stage dut (
    .clk        (clk),
    .rst        (rst),
    .pc_in      (pc_in),
    .instr_in   (instr_in),
    .valid_in   (valid_in),
    .stall_in   (stall_in),
    .flush      (flush),
    .wb_en      (wb_en),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .stall_fe   (stall_fe),
    .valid_out  (valid_out),
    .pc_out     (pc_out),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .rs1        (rs1),
    .rs2        (rs2),
    .rd         (rd),
    .imm        (imm),
    .alu_op     (alu_op),
    .reg_write  (reg_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .branch     (branch),
    .jump       (jump),
    .funct3_out (funct3_out),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] ins, input logic v);
    pc_in    = pc;
    instr_in = ins;
    valid_in = v;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    stall_in = 1'b0;
    flush    = 1'b0;
    wb_en    = 1'b0;
    wb_rd    = 5'd0;
    wb_data  = 32'd0;
    drive(32'd0, 32'd0, 1'b0);

    step();
    step();
    chk("rst_valid",   32'(valid_out), 32'd0);
    chk("rst_stallfe", 32'(stall_fe),  32'd0);
    chk("rst_pc",      pc_out,         32'd0);
    chk("rst_imm",     imm,            32'd0);
    chk("rst_ctrl",    32'({reg_write, mem_read, mem_write, branch, jump, illegal}), 32'd0);
    rst = 1'b0;

    // ADDI x1,x0,5
    drive(32'd4, I_ADDI, 1'b1);
    step();
    chk("addi_valid", 32'(valid_out), 32'd1);
    chk("addi_pc",    pc_out,         32'd4);
    chk("addi_rd",    32'(rd),        32'd1);
    chk("addi_rs1",   32'(rs1),       32'd0);
    chk("addi_imm",   imm,            32'd5);
    chk("addi_alu",   32'(alu_op),    32'(ALU_ADD));
    chk("addi_rw",    32'(reg_write), 32'd1);

    // Bypass of x1 write into rs2 of ADD x3,x2,x1
    drive(32'd5, I_ADD, 1'b1);
    wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'h1234;
    step();
    chk("byp_rs2data", rs2_data,        32'h1234);
    chk("byp_rs1data", rs1_data,        32'd0);
    chk("add_rd",      32'(rd),         32'd3);
    chk("add_imm",     imm,             32'd0);
    // x0 write is dropped; x1 now comes from the array
    drive(32'd6, I_ADD0, 1'b1);
    wb_rd = 5'd0; wb_data = 32'hDEAD;
    step();
    chk("x0_rs1data",  rs1_data,        32'd0);
    chk("x1_stored",   rs2_data,        32'h1234);
    wb_en = 1'b0;

    // Load-use: LW x2 then ADD x3,x2,x1
    drive(32'd8, I_LW, 1'b1);
    step();
    chk("lw_memread", 32'(mem_read),   32'd1);
    chk("lw_f3",      32'(funct3_out), 32'd2);
    chk("lw_rs1data", rs1_data,        32'h1234);
    drive(32'd9, I_ADD, 1'b1);
    #1;
    chk("lu_stall",    32'(stall_fe),  32'd1);
    step();
    chk("bub_valid",   32'(valid_out), 32'd0);
    chk("bub_memread", 32'(mem_read),  32'd0);
    chk("bub_rw",      32'(reg_write), 32'd0);
    chk("lu_stall_1c", 32'(stall_fe),  32'd0);
    step();
    chk("lu_add_valid", 32'(valid_out), 32'd1);
    chk("lu_add_pc",    pc_out,         32'd9);
    chk("lu_add_rd",    32'(rd),        32'd3);

    // Load-use with flush in the hazard cycle
    drive(32'd10, I_LW, 1'b1);
    step();
    drive(32'd11, I_ADD, 1'b1);
    flush = 1'b1;
    #1;
    chk("fl_stall", 32'(stall_fe), 32'd0);
    step();
    chk("fl_valid", 32'(valid_out), 32'd0);
    flush = 1'b0;

    // BEQ x0,x0,-8
    drive(32'h20, I_BEQ, 1'b1);
    step();
    chk("beq_imm", imm,             32'hFFFFFFF8);
    chk("beq_br",  32'(branch),     32'd1);
    chk("beq_rw",  32'(reg_write),  32'd0);
    chk("beq_alu", 32'(alu_op),     32'(ALU_SUB));

    // JAL x1,8 and LUI x5,0x12345
    drive(32'h21, I_JAL, 1'b1);
    step();
    chk("jal_imm",  imm,            32'd8);
    chk("jal_jump", 32'(jump),      32'd1);
    chk("jal_rw",   32'(reg_write), 32'd1);
    drive(32'h22, I_LUI, 1'b1);
    step();
    chk("lui_imm", imm,          32'h12345000);
    chk("lui_alu", 32'(alu_op),  32'(ALU_PASS_B));
    chk("lui_rd",  32'(rd),      32'd5);

    // Unsupported opcode
    drive(32'h23, 32'hFFFFFFFF, 1'b1);
    step();
    chk("ill_flag", 32'(illegal), 32'd1);
    chk("ill_ctrl", 32'({reg_write, mem_read, mem_write, branch, jump}), 32'd0);

    // Reset mid-stream discards a pending hazard
    drive(32'h30, I_LW, 1'b1);
    step();
    drive(32'h31, I_ADD, 1'b1);
    rst = 1'b1;
    #1;
    chk("mrst_stall_in", 32'(stall_fe), 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("mrst_valid", 32'(valid_out), 32'd0);
    chk("mrst_stall", 32'(stall_fe),  32'd0);

    // stall_in holds ID/EX for three cycles
    drive(32'h40, I_ADDI, 1'b1);
    step();
    stall_in = 1'b1;
    drive(32'h80, I_BEQ, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_pc",    pc_out,         32'h40);
      chk("hold_imm",   imm,            32'd5);
      chk("hold_valid", 32'(valid_out), 32'd1);
    end

    // flush beats stall_in
    flush = 1'b1;
    step();
    chk("fl_over_st", 32'(valid_out), 32'd0);
    flush    = 1'b0;
    stall_in = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
